mc_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_ctrl_alu_dec.sv | 22 ++
 rtl/mc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EX,
    S_R_WB,
    S_BR,
    S_JMP,
    S_I_EX,
    S_I_WB
`ifdef MC_CTRL_JAL_EN
    , S_JAL
`endif
  } state_t;

  typedef enum logic [2:0] {
    ALU_IDLE = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_SUB  = 3'b101,
    ALU_SLT  = 3'b111
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic [1:0] REG_DST_RT   = 2'b00;
  localparam logic [1:0] REG_DST_RD   = 2'b01;
  localparam logic [1:0] REG_DST_RA   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_BRANCH  = 2'b11;
  localparam logic       EXT_ZERO     = 1'b0;
  localparam logic       EXT_SIGN     = 1'b1;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decode: ALU operation plus a valid flag for unsupported funct codes.
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_IDLE;
    valid_o  = 1'b0;
    case (funct_i)
      FN_ADDU: begin alu_op_o = ALU_ADD; valid_o = 1'b1; end
      FN_SUBU: begin alu_op_o = ALU_SUB; valid_o = 1'b1; end
      FN_OR:   begin alu_op_o = ALU_OR;  valid_o = 1'b1; end
      FN_SLT:  begin alu_op_o = ALU_SLT; valid_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving ALU, muxes and memory strobes.
// Define MC_CTRL_JAL_EN to support jal (op 000011); otherwise it is illegal.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] pc_src,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] dec_alu_op;
  logic       dec_valid;

  alu_dec u_alu_dec (
    .funct_i  (funct),
    .alu_op_o (dec_alu_op),
    .valid_o  (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

  // Outputs decode from the registered state so an async reset clears them instantly.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    ALUop      = ALU_IDLE;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    iord       = IORD_PC;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    ext_op     = EXT_ZERO;
    pc_src     = PCSRC_ALU;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        ALUop     = ALU_ADD;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUop     = ALU_ADD;
        alu_src_b = SRCB_BRANCH;
        case (op)
          OP_RTYPE:     state_d = S_R_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BR;
          OP_J:         state_d = S_JMP;
          OP_ORI:       state_d = S_I_EX;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_R_EX: begin
        alu_src_a = SRCA_REG;
        ALUop     = dec_alu_op;
        if (dec_valid) begin
          state_d = S_R_WB;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = REG_DST_RD;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUop     = ALU_ADD;
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        ext_op    = EXT_SIGN;
        state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = IORD_ALUOUT;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_MDR;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = IORD_ALUOUT;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BR: begin
        ALUop     = ALU_SUB;
        alu_src_a = SRCA_REG;
        pc_src    = PCSRC_ALUOUT;
        pc_wr     = zero;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_wr   = 1'b1;
        pc_src  = PCSRC_JUMP;
        state_d = S_FETCH;
      end
      S_I_EX: begin
        ALUop     = ALU_OR;
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        reg_wr     = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
        pc_wr      = 1'b1;
        pc_src     = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each stimulus cycle queues its expected output
// vector; a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic [2:0] ALUop;
  logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       alu_src_a, ext_op, illegal;

  int checks = 0;
  int errors = 0;

  logic [19:0] expq[$];
  string       tagq[$];
  logic [19:0] got;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALUop(ALUop), .pc_wr(pc_wr), .ir_wr(ir_wr),
    .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .pc_src(pc_src), .illegal(illegal)
  );

  // Vector layout: ALUop,pc_wr,ir_wr,iord,mem_rd,mem_wr,reg_wr,reg_dst,mem_to_reg,src_a,src_b,ext,pc_src,illegal
  assign got = {ALUop, pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, ext_op, pc_src, illegal};

  function automatic logic [19:0] ov(input logic [2:0] a, input logic pw, iw, io, mr, mw, rw,
                                     input logic [1:0] rd, m2, input logic sa,
                                     input logic [1:0] sb, input logic ex,
                                     input logic [1:0] ps, input logic il);
    return {a, pw, iw, io, mr, mw, rw, rd, m2, sa, sb, ex, ps, il};
  endfunction

  function automatic logic [19:0] e_fetch(input logic r, input logic il);
    return ov(3'b001, r, r, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_dec(input logic il);
    return ov(3'b001, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_rex(input logic [2:0] a, input logic il);
    return ov(a, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_rwb(input logic il);
    return ov(3'b000, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_madr(input logic il);
    return ov(3'b001, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 1, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_mrd(input logic il);
    return ov(3'b000, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_mwb(input logic il);
    return ov(3'b000, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_mwr(input logic il);
    return ov(3'b000, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_br(input logic z, input logic il);
    return ov(3'b101, z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b01, il);
  endfunction
  function automatic logic [19:0] e_jmp(input logic il);
    return ov(3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b10, il);
  endfunction
  function automatic logic [19:0] e_iex(input logic il);
    return ov(3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 2'b00, il);
  endfunction
  function automatic logic [19:0] e_iwb(input logic il);
    return ov(3'b000, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, il);
  endfunction
`ifdef MC_CTRL_JAL_EN
  function automatic logic [19:0] e_jal(input logic il);
    return ov(3'b000, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 2'b10, il);
  endfunction
`endif

  // Drive one cycle's inputs and queue what the outputs must be in that cycle.
  task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic r, input logic [19:0] e);
    op = o; funct = f; zero = z; mem_ready = r;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [19:0] e;
      string       t;
      e = expq.pop_front();
      t = tagq.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", t, got, e);
      end
    end
  end

  localparam logic [5:0] R0 = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JJ = 6'b000010, ORI = 6'b001101;
  localparam logic [5:0] JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] ADDU = 6'b100001, SLT = 6'b101010;
  localparam logic [19:0] Z = 20'h0;

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", R0, ADDU, 0, 1, Z);
    rst_n = 1'b1;
    cyc("idle", R0, ADDU, 0, 1, Z);
    // addu
    cyc("addu_fetch", R0, ADDU, 0, 1, e_fetch(1, 0));
    cyc("addu_dec",   R0, ADDU, 0, 1, e_dec(0));
    cyc("addu_rex",   R0, ADDU, 0, 1, e_rex(3'b001, 0));
    cyc("addu_rwb",   R0, ADDU, 0, 1, e_rwb(0));
    // lw with two wait cycles in MEM_RD
    cyc("lw_fetch",  LW, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("lw_dec",    LW, 6'h00, 0, 1, e_dec(0));
    cyc("lw_addr",   LW, 6'h00, 0, 1, e_madr(0));
    cyc("lw_rd_w0",  LW, 6'h00, 0, 0, e_mrd(0));
    cyc("lw_rd_w1",  LW, 6'h00, 0, 0, e_mrd(0));
    cyc("lw_rd_ok",  LW, 6'h00, 0, 1, e_mrd(0));
    cyc("lw_wb",     LW, 6'h00, 0, 1, e_mwb(0));
    // sw with a fetch wait
    cyc("sw_fetch_w", SW, 6'h00, 0, 0, e_fetch(0, 0));
    cyc("sw_fetch",   SW, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("sw_dec",     SW, 6'h00, 0, 1, e_dec(0));
    cyc("sw_addr",    SW, 6'h00, 0, 1, e_madr(0));
    cyc("sw_wr",      SW, 6'h00, 0, 1, e_mwr(0));
    // ori
    cyc("ori_fetch", ORI, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("ori_dec",   ORI, 6'h00, 0, 1, e_dec(0));
    cyc("ori_ex",    ORI, 6'h00, 0, 1, e_iex(0));
    cyc("ori_wb",    ORI, 6'h00, 0, 1, e_iwb(0));
    // beq taken / not taken
    cyc("beq1_fetch", BEQ, 6'h00, 1, 1, e_fetch(1, 0));
    cyc("beq1_dec",   BEQ, 6'h00, 1, 1, e_dec(0));
    cyc("beq1_br",    BEQ, 6'h00, 1, 1, e_br(1, 0));
    cyc("beq0_fetch", BEQ, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("beq0_dec",   BEQ, 6'h00, 0, 1, e_dec(0));
    cyc("beq0_br",    BEQ, 6'h00, 0, 1, e_br(0, 0));
    // j
    cyc("j_fetch", JJ, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("j_dec",   JJ, 6'h00, 0, 1, e_dec(0));
    cyc("j_jmp",   JJ, 6'h00, 0, 1, e_jmp(0));
    // illegal opcode, then slt with the flag held
    cyc("bad_fetch", BAD, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("bad_dec",   BAD, 6'h00, 0, 1, e_dec(0));
    cyc("slt_fetch", R0, SLT, 0, 1, e_fetch(1, 1));
    cyc("slt_dec",   R0, SLT, 0, 1, e_dec(1));
    cyc("slt_rex",   R0, SLT, 0, 1, e_rex(3'b111, 1));
    cyc("slt_rwb",   R0, SLT, 0, 1, e_rwb(1));
    // async reset in the middle of a stalled store
    cyc("swr_fetch", SW, 6'h00, 0, 1, e_fetch(1, 1));
    cyc("swr_dec",   SW, 6'h00, 0, 1, e_dec(1));
    cyc("swr_addr",  SW, 6'h00, 0, 1, e_madr(1));
    cyc("swr_wr_w",  SW, 6'h00, 0, 0, e_mwr(1));
    rst_n = 1'b0;
    cyc("swr_rst_now", SW, 6'h00, 0, 0, Z);
    rst_n = 1'b1;
    cyc("swr_idle",  SW, 6'h00, 0, 1, Z);
    cyc("jal_fetch", JAL, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("jal_dec",   JAL, 6'h00, 0, 1, e_dec(0));
`ifdef MC_CTRL_JAL_EN
    cyc("jal_jal",   JAL, 6'h00, 0, 1, e_jal(0));
    cyc("jal_next",  R0, 6'h00, 0, 1, e_fetch(1, 0));
`else
    cyc("jal_ill",   R0, 6'h00, 0, 1, e_fetch(1, 1));
`endif
    // illegal funct from a clean flag
    rst_n = 1'b0;
    cyc("rst2", R0, 6'h00, 0, 1, Z);
    rst_n = 1'b1;
    cyc("rst2_idle",  R0, 6'h00, 0, 1, Z);
    cyc("fn_fetch",   R0, 6'h00, 0, 1, e_fetch(1, 0));
    cyc("fn_dec",     R0, 6'h00, 0, 1, e_dec(0));
    cyc("fn_rex",     R0, 6'h00, 0, 1, e_rex(3'b000, 0));
    cyc("fn_refetch", R0, 6'h00, 0, 1, e_fetch(1, 1));

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
